// File: rtl/bridge_utils_pkg.sv
// Shared types for the AXI2APB bridge: response codes, latched AR/AW info,
// and the read-channel responder's state encoding.
package bridge_utils;

    localparam int ID_WIDTH = 4;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    // Address-phase fields handed to the engine; the write receiver uses the same layout.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } addr_info_t;

    typedef enum logic [2:0] {
        WR_IDLE   = 3'd0,
        WR_AR     = 3'd1,
        WR_R_WAIT = 3'd2,
        WR_R_SEND = 3'd3,
        WR_DONE   = 3'd4
    } writer_state_e;

endpackage

// File: rtl/slave_axi_writer.sv
// AXI read-channel responder: takes one AR per engine command, then drains the
// show-ahead read-data FIFO onto the R channel one beat per handshake.
module slave_axi_writer
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  eng_start,
    output logic                  eng_addr_valid,
    output logic [ADDR_WIDTH-1:0] eng_addr,
    output logic [3:0]            eng_len,
    output logic [2:0]            eng_size,
    output logic [1:0]            eng_burst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic [1:0]            fifo_rresp,
    output logic                  fifo_read,
    output logic                  eng_busy,
    output logic                  eng_done
);

    writer_state_e         state_q, state_d;
    addr_info_t            info_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [3:0]            beat_cnt;
    logic [3:0]            beat_nxt;
    logic [DATA_WIDTH-1:0] rdata_q;
    resp_e                 rresp_q;
    logic                  rlast_q;
    logic                  addr_vld_q;
    logic                  ar_hs;
    logic                  r_adv;

    assign ar_hs = arready && arvalid;
    // A non-final beat accepted by the master; the counter moves on to the next beat.
    assign r_adv = (state_q == WR_R_SEND) && rready && !rlast_q;
    // Index of the beat being loaded: a pop in R_SEND fetches the beat after the one on the bus.
    assign beat_nxt = (state_q == WR_R_SEND) ? 4'(beat_cnt + 4'd1) : beat_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WR_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:   if (eng_start) state_d = WR_AR;
            WR_AR:     if (arvalid) state_d = WR_R_WAIT;
            WR_R_WAIT: if (!fifo_empty) state_d = WR_R_SEND;
            WR_R_SEND: begin
                if (rready) begin
                    if (rlast_q)         state_d = WR_DONE;
                    else if (fifo_empty) state_d = WR_R_WAIT;
                end
            end
            WR_DONE:   state_d = WR_IDLE;
            default:   state_d = WR_IDLE;
        endcase
    end

    // State-decoded outputs; the pop strobe is combinational so the FIFO head is consumed the same cycle
    always_comb begin
        arready   = 1'b0;
        rvalid    = 1'b0;
        fifo_read = 1'b0;
        eng_busy  = (state_q != WR_IDLE);
        eng_done  = 1'b0;
        case (state_q)
            WR_AR:     arready = 1'b1;
            WR_R_WAIT: fifo_read = !fifo_empty;
            WR_R_SEND: begin
                rvalid    = 1'b1;
                fifo_read = r_adv && !fifo_empty;
            end
            WR_DONE:   eng_done = 1'b1;
            default:   ;
        endcase
    end

    // AR latch, beat counter and R-channel output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            info_q     <= '0;
            rid_q      <= '0;
            beat_cnt   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            addr_vld_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid_q        <= arid;
                info_q.addr  <= ADDR_W'(araddr);
                info_q.len   <= arlen;
                info_q.size  <= arsize;
                info_q.burst <= arburst;
                beat_cnt     <= '0;
                addr_vld_q   <= 1'b1;
            end
            if (r_adv) beat_cnt <= beat_nxt;
            if (fifo_read) begin
                rdata_q <= fifo_rdata;
                rresp_q <= resp_e'(fifo_rresp);
                rlast_q <= (beat_nxt == info_q.len);
            end
            if (state_q == WR_DONE) begin
                addr_vld_q <= 1'b0;
                rlast_q    <= 1'b0;
            end
        end
    end

    assign rid            = rid_q;
    assign rdata          = rdata_q;
    assign rresp          = rresp_q;
    assign rlast          = rlast_q;
    assign eng_addr_valid = addr_vld_q;
    assign eng_addr       = ADDR_WIDTH'(info_q.addr);
    assign eng_len        = info_q.len;
    assign eng_size       = info_q.size;
    assign eng_burst      = info_q.burst;

endmodule

// File: tb/tb_slave_axi_writer.sv
// Directed bench for slave_axi_writer: a queue-based FIFO model feeds the DUT,
// and a per-cycle scoreboard checks every R beat, stalls and the done pulse.
module tb_slave_axi_writer;
    import bridge_utils::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ID_WIDTH-1:0] arid = '0;
    logic [31:0]         araddr = '0;
    logic [3:0]          arlen = '0;
    logic [2:0]          arsize = '0;
    logic [1:0]          arburst = '0;
    logic                arvalid = 1'b0;
    logic                arready;
    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast, rvalid;
    logic                rready = 1'b1;
    logic                eng_start = 1'b0;
    logic                eng_addr_valid;
    logic [31:0]         eng_addr;
    logic [3:0]          eng_len;
    logic [2:0]          eng_size;
    logic [1:0]          eng_burst;
    logic                fifo_empty = 1'b1;
    logic [31:0]         fifo_rdata = '0;
    logic [1:0]          fifo_rresp = '0;
    logic                fifo_read, eng_busy, eng_done;

    slave_axi_writer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .eng_start(eng_start), .eng_addr_valid(eng_addr_valid), .eng_addr(eng_addr),
        .eng_len(eng_len), .eng_size(eng_size), .eng_burst(eng_burst),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rresp(fifo_rresp),
        .fifo_read(fifo_read), .eng_busy(eng_busy), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } beat_t;

    beat_t       fq[$];      // FIFO contents seen by the DUT
    beat_t       exp_q[$];   // beats the R channel must still deliver, in order
    int          tests = 0, fails = 0;
    int          pops = 0;
    logic        pop_pending = 1'b0;
    logic [3:0]  cur_len = '0;
    logic [ID_WIDTH-1:0] cur_id = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: apply the pop seen on the previous half-cycle, then present the head.
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
            pop_pending = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? 32'h0 : fq[0].d;
        fifo_rresp = fifo_empty ? 2'h0 : fq[0].r;
        #3;
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? 32'h0 : fq[0].d;
        fifo_rresp = fifo_empty ? 2'h0 : fq[0].r;
    end

    // Scoreboard: beat order/content, rlast at beat index == len, stall stability, done pulse.
    int          beat_idx = 0;
    logic        done_due = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] sv_data;
    logic        sv_last;
    logic [1:0]  sv_resp;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            beat_idx = 0; done_due = 1'b0; stall = 1'b0; pop_pending = 1'b0;
        end else begin
            pop_pending = fifo_read;
            check("eng_done_pulse", eng_done, done_due);
            done_due = 1'b0;
            check("no_pop_when_empty", fifo_read & fifo_empty, 0);
            if (stall) begin
                check("stall_rvalid", rvalid, 1);
                check("stall_rdata", rdata, sv_data);
                check("stall_rlast", rlast, sv_last);
                check("stall_rresp", rresp, sv_resp);
            end
            if (rvalid && !rready) begin
                check("stall_no_pop", fifo_read, 0);
                stall = 1'b1; sv_data = rdata; sv_last = rlast; sv_resp = rresp;
            end else stall = 1'b0;
            if (rvalid && rready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat_rdata", rdata, e.d);
                    check("beat_rresp", rresp, e.r);
                end
                check("beat_rid", rid, cur_id);
                check("beat_rlast", rlast, beat_idx == int'(cur_len));
                if (beat_idx == int'(cur_len)) begin done_due = 1'b1; beat_idx = 0; end
                else beat_idx++;
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [1:0] r);
        beat_t b;
        b.d = d; b.r = r;
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    // Command the engine, present AR, and check the latched fields.
    task automatic run_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        @(posedge clk); #1;
        cur_id = id; cur_len = len;
        eng_start = 1'b1; arvalid = 1'b1;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'd1;
        @(posedge clk); #1;
        eng_start = 1'b0;
        check("arready_in_ar", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("eng_addr_valid", eng_addr_valid, 1);
        check("eng_addr", eng_addr, addr);
        check("eng_len", eng_len, len);
        check("eng_size", eng_size, 2);
        check("eng_burst", eng_burst, 1);
    endtask

    task automatic wait_rvalid();
        int n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("rvalid_timeout", rvalid, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!eng_done && n < 100) begin @(negedge clk); n++; end
        check("done_timeout", eng_done, 1);
        @(negedge clk);
        check("idle_busy", eng_busy, 0);
        check("idle_addr_valid", eng_addr_valid, 0);
        check("idle_rlast", rlast, 0);
    endtask

    initial begin
        int p0;
        // Reset state
        #2;
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rid", rid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_busy", eng_busy, 0);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_eng_addr", eng_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single beat
        push(32'hDEADBEEF, 2'd0);
        p0 = pops;
        run_ar(4'd3, 32'h1000, 4'd0);
        @(negedge clk);
        check("sb_pop", fifo_read, 1);
        check("sb_rvalid_lo", rvalid, 0);
        @(negedge clk);
        check("sb_rvalid", rvalid, 1);
        check("sb_rdata", rdata, 32'hDEADBEEF);
        check("sb_rid", rid, 3);
        check("sb_rresp", rresp, 0);
        check("sb_rlast", rlast, 1);
        @(negedge clk);
        check("sb_done", eng_done, 1);
        wait_done();
        check("sb_pops", pops - p0, 1);

        // Back-to-back burst
        push(32'h11, 0); push(32'h22, 0); push(32'h33, 0); push(32'h44, 0);
        p0 = pops;
        run_ar(4'd5, 32'h2000, 4'd3);
        wait_rvalid();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'h11 * (i + 1);
            check("b2b_rvalid", rvalid, 1);
            check("b2b_rdata", rdata, w);
            check("b2b_rlast", rlast, i == 3);
            @(negedge clk);
        end
        wait_done();
        check("b2b_pops", pops - p0, 4);

        // Backpressure on beat 2
        push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 0); push(32'hA4, 0);
        p0 = pops;
        run_ar(4'd6, 32'h3000, 4'd3);
        wait_rvalid();
        @(posedge clk); #1;
        rready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_rdata", rdata, 32'hA2);
            check("bp_rlast", rlast, 0);
            check("bp_no_pop", fifo_read, 0);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        wait_done();
        check("bp_pops", pops - p0, 4);

        // Underrun between beat 1 and beat 2
        push(32'hB1, 0);
        run_ar(4'd7, 32'h4000, 4'd1);
        wait_rvalid();
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            check("ur_gap_rvalid", rvalid, 0);
        end
        @(posedge clk); #2;
        push(32'hB2, 0);
        @(negedge clk);
        check("ur_pop", fifo_read, 1);
        check("ur_rvalid_lo", rvalid, 0);
        @(negedge clk);
        check("ur_rvalid", rvalid, 1);
        check("ur_rdata", rdata, 32'hB2);
        check("ur_rlast", rlast, 1);
        wait_done();

        // Per-beat error response, then AR guard without eng_start
        push(32'hC1, 2); push(32'hC2, 0);
        run_ar(4'd9, 32'h5000, 4'd1);
        wait_rvalid();
        check("err_beat1", rresp, 2);
        @(negedge clk);
        check("err_beat2", rresp, 0);
        check("err_rlast", rlast, 1);
        wait_done();
        @(posedge clk); #1;
        arvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("guard_arready", arready, 0);
        end
        push(32'hD1, 0);
        run_ar(4'd2, 32'h6000, 4'd0);
        wait_rvalid();
        check("guard_rdata", rdata, 32'hD1);
        wait_done();

        // Reset in the middle of an 8-beat burst
        for (int i = 0; i < 8; i++) push(32'hE0 + i, 0);
        run_ar(4'd4, 32'h7000, 4'd7);
        wait_rvalid();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mr_rvalid", rvalid, 0);
        check("mr_rdata", rdata, 0);
        check("mr_rlast", rlast, 0);
        check("mr_rid", rid, 0);
        check("mr_addr_valid", eng_addr_valid, 0);
        check("mr_eng_addr", eng_addr, 0);
        check("mr_busy", eng_busy, 0);
        check("mr_fifo_read", fifo_read, 0);
        fq.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_idle_busy", eng_busy, 0);
        check("mr_idle_arready", arready, 0);
        push(32'hF00D, 0);
        run_ar(4'd1, 32'h8000, 4'd0);
        wait_rvalid();
        check("mr_fresh_rdata", rdata, 32'hF00D);
        check("mr_fresh_rlast", rlast, 1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slave_axi_writer.md
Name: slave_axi_writer

Overview:
- AXI slave read-channel responder for the AXI2APB bridge: accepts one AR request per engine command and returns the read burst on the R channel.
- The engine issues the APB reads and fills a show-ahead (first-word-fall-through) read-data FIFO; this block pops that FIFO and drives rdata/rresp/rlast with full valid/ready handshaking.
- Sits beside the AXI write-channel receiver, on the same engine command/status style of interface.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI/FIFO data width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- arid  input  ID_WIDTH  read ID
- araddr  input  ADDR_WIDTH  read address
- arlen  input  4  beats-1 (1..16 beats)
- arsize  input  3  beat size
- arburst  input  2  burst type
- arvalid  input  1  AR valid
- arready  output  1  AR ready
- rid  output  ID_WIDTH  read ID, equal to latched arid
- rdata  output  DATA_WIDTH  read data
- rresp  output  2  per-beat response
- rlast  output  1  final beat
- rvalid  output  1  R valid
- rready  input  1  R ready
- eng_start  input  1  engine permits accepting one AR; ignored unless in IDLE
- eng_addr_valid  output  1  latched AR info valid, for the engine
- eng_addr, eng_len, eng_size, eng_burst  output  ADDR_WIDTH/4/3/2  latched AR fields
- fifo_empty  input  1  read-data FIFO empty
- fifo_rdata  input  DATA_WIDTH  FIFO head data
- fifo_rresp  input  2  FIFO head response (0 = OKAY, 2 = SLVERR)
- fifo_read  output  1  pop strobe; one pop per beat
- eng_busy  output  1  high in every state except IDLE
- eng_done  output  1  one-cycle pulse when the burst completes

Behaviour:
- Reset: state IDLE; every output 0, including the latched ID, AR fields, rdata, rresp, rlast and the beat counter. Reset in mid-burst aborts the burst with no further pops or beats.
- States: IDLE, AR, R_WAIT, R_SEND, DONE.
- IDLE:
  - arready=0.
  - eng_start=1 -> AR next cycle.
- AR:
  - arready=1.
  - On arvalid: latch arid/araddr/arlen/arsize/arburst and clear beat_cnt -> R_WAIT.
  - eng_addr_valid is registered: high from the cycle after the handshake until DONE.
- R_WAIT:
  - rvalid=0.
  - If !fifo_empty: fifo_read=1 (combinational), register fifo_rdata->rdata and fifo_rresp->rresp, set rlast=(beat_cnt==len) -> R_SEND.
  - Latency from FIFO non-empty to rvalid is 1 cycle.
- R_SEND:
  - rvalid=1.
  - rdata/rresp/rlast hold stable while rready=0, and fifo_read=0 during that stall.
  - On rready with rlast=1 -> DONE.
  - On rready with rlast=0: beat_cnt+1. If !fifo_empty, pop in the same cycle, load the next beat and stay in R_SEND (back-to-back, one beat per cycle). Otherwise -> R_WAIT with rvalid dropping next cycle.
- DONE:
  - eng_done=1 for one cycle; clear eng_addr_valid, rvalid and rlast -> IDLE.
  - A new AR can be accepted no earlier than 2 cycles after the final R handshake.
- beat_cnt is 4 bits; no wrap is possible because rlast terminates at beat_cnt==arlen (arlen=15 gives 16 beats).
- rresp is per beat straight from the FIFO with no aggregation; a SLVERR beat does not shorten the burst.
- arvalid outside AR is never acknowledged. eng_start outside IDLE is ignored.
- The FIFO is never popped outside R_WAIT and R_SEND.

Decomposition:
- Package bridge_utils holds:
  - ID_WIDTH
  - resp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - addr_info_t {addr, len, size, burst}, shared with the write receiver
  - the writer state enum
- Single module with no sub-module. Beat counter and output registers stay inline.

Test Plan:
- Single beat:
  - Stimulus: eng_start; AR arid=3, araddr=0x1000, arlen=0; FIFO head 0xDEADBEEF/OKAY.
  - Required: one pop; rvalid 1 cycle later with rdata=0xDEADBEEF, rid=3, rresp=0, rlast=1; eng_done pulse the cycle after the R handshake; eng_addr=0x1000.
- Back-to-back burst:
  - Stimulus: arlen=3, FIFO preloaded with 0x11,0x22,0x33,0x44, rready held 1.
  - Required: 4 consecutive R beats in 4 cycles, rlast only on 0x44, exactly 4 pops.
- Backpressure:
  - Stimulus: rready=0 for 3 cycles on beat 2 of an arlen=3 burst.
  - Required: rvalid=1 and rdata/rlast unchanged, fifo_read=0 throughout; burst completes correctly.
- Underrun:
  - Stimulus: FIFO empty after beat 1 of arlen=1 for 4 cycles.
  - Required: rvalid=0 during the gap; beat 2 appears 1 cycle after fifo_empty falls, with rlast=1.
- Error and protocol guard:
  - Stimulus: fifo_rresp=2 on beat 1 of an arlen=1 burst; then arvalid=1 with no eng_start.
  - Required: rresp=2 on beat 1 and 0 on beat 2; arready stays 0 until eng_start is given.
- Reset mid-burst:
  - Stimulus: rst_n low during beat 2 of an arlen=7 burst.
  - Required: all outputs 0 immediately; after release, state IDLE, and a fresh arlen=0 transfer completes normally.
